// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Instruction fetch front end feeding the decode stage. Owns the fetch PC,
// issues single-word reads to a variable-latency instruction memory (at most
// one outstanding), and buffers returned words together with their PC+4 in a
// DEPTH-entry FIFO. The FIFO head is presented show-ahead to decode.
// A redirect (PCSrcD) flushes the FIFO, retargets the fetch PC and, if a read
// is still in flight, drops its response when it finally arrives.
//
// Ports
//   Clk          in   1   clock, all state updates on posedge
//   reset        in   1   asynchronous, active-high
//   imem_req     out  1   one-cycle read request
//   imem_addr    out  32  request byte address (always word aligned)
//   imem_rvalid  in   1   read response valid
//   imem_rdata   in   32  read response data
//   StallD       in   1   decode cannot accept the head this cycle
//   PCSrcD       in   1   redirect from decode (taken branch/jump)
//   PCBranchD    in   32  redirect target, low two bits ignored
//   ValidD       out  1   FIFO head valid
//   InstrD       out  32  head instruction, 0 when ValidD=0
//   PCPlus4D     out  32  head instruction's PC+4, 0 when ValidD=0
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // IDLE: nothing in flight. WAIT: one read in flight, response is kept.
    // DROP: one read in flight whose response belongs to a flushed path.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t        state_q,    state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q,   req_pc_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];

    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] count_after;
    logic [31:0]   target_pc;

    assign target_pc = PCBranchD & 32'hFFFF_FFFC;

    // Show-ahead head; zeroed when empty so decode never sees stale entries.
    assign ValidD    = (count_q != '0);
    assign InstrD    = ValidD ? instr_mem[rd_ptr_q] : 32'h0;
    assign PCPlus4D  = ValidD ? pc4_mem[rd_ptr_q]   : 32'h0;

    // fetch_pc_q is always the next address to fetch, so the address bus
    // simply mirrors it; imem_req qualifies it.
    assign imem_addr = fetch_pc_q;
    assign imem_req  = issue;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave it
        // unassigned and infer a latch.
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        pop         = ValidD && !StallD && !PCSrcD;
        push        = (state_q == S_WAIT) && imem_rvalid && !PCSrcD;
        count_after = count_q + CW'(push) - CW'(pop);

        // From IDLE space is judged on the current occupancy; on a returning
        // response it is judged on the occupancy after this cycle's push/pop,
        // which is what allows one fetch per cycle with a 1-cycle memory.
        issue = 1'b0;
        if (!reset && !PCSrcD) begin
            if (state_q == S_IDLE) begin
                issue = (count_q < DEPTH_C);
            end else if (state_q == S_WAIT) begin
                issue = imem_rvalid && (count_after < DEPTH_C);
            end
        end

        if (PCSrcD) begin
            // Redirect wins over push, pop and issue.
            fetch_pc_d = target_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A read still in flight must be drained before refetching.
            if ((state_q != S_IDLE) && !imem_rvalid) begin
                state_d = S_DROP;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_after;
            if (issue) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            unique case (state_q)
                S_IDLE: if (issue)       state_d = S_WAIT;
                S_WAIT: if (imem_rvalid) state_d = issue ? S_WAIT : S_IDLE;
                S_DROP: if (imem_rvalid) state_d = S_IDLE;
                default:                 state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only observable
    // through ValidD, which is derived from the reset count.
    always_ff @(posedge Clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc4_mem[wr_ptr_q]   <= req_pc_q + 32'd4;
        end
    end

    // Issue is gated by space, so a push into a full FIFO without a pop
    // can only come from a broken space calculation.
    a_no_overflow: assert property (@(posedge Clk) disable iff (reset)
        !(push && !pop && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_queue
//
// Drives fetch_prefetch_queue with a bench-side instruction memory (fixed or
// random latency, random data) and compares every cycle against a queue-based
// reference model of the fetch front end, plus directed constant checks for
// streaming, stall fill, long latency, redirects, mid-run reset and PC wrap.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;

    int checks = 0;
    int errors = 0;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .ValidD     (ValidD),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D)
    );

    always #5 Clk = ~Clk;

    wire [97:0] dut_out = {imem_req, imem_addr, ValidD, InstrD, PCPlus4D};

    // ---------------- bench instruction memory ----------------
    bit mem_pend;
    int mem_wait;
    int mem_lat;
    bit mem_rand;
    int req_count;

    // ---------------- reference model ----------------
    // fq holds {pc+4, instr} for each buffered instruction, oldest first.
    logic [63:0] fq[$];
    logic [31:0] m_pc;
    logic [31:0] m_reqpc;
    bit          m_out;   // a read is in flight
    bit          m_drop;  // ... and its data belongs to a flushed path
    logic [97:0] exp_out;
    bit          exp_push, exp_pop, exp_issue;

    function automatic void model_reset();
        fq.delete();
        m_pc    = RESET_PC;
        m_reqpc = RESET_PC;
        m_out   = 1'b0;
        m_drop  = 1'b0;
    endfunction

    function automatic void model_expect();
        int  after;
        bit  resp;
        resp     = imem_rvalid && m_out && !m_drop;
        exp_pop  = (fq.size() != 0) && !StallD && !PCSrcD;
        exp_push = resp && !PCSrcD;
        after    = fq.size() + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
        if (PCSrcD)      exp_issue = 1'b0;
        else if (!m_out) exp_issue = (fq.size() < DEPTH);
        else             exp_issue = resp && (after < DEPTH);
        exp_out = {exp_issue, m_pc, 1'b0, 32'h0, 32'h0};
        if (fq.size() != 0) exp_out = {exp_issue, m_pc, 1'b1, fq[0][31:0], fq[0][63:32]};
    endfunction

    function automatic void model_update();
        if (PCSrcD) begin
            fq.delete();
            m_pc = PCBranchD & 32'hFFFF_FFFC;
            if (m_out && !imem_rvalid) m_drop = 1'b1;
            else begin m_out = 1'b0; m_drop = 1'b0; end
        end else begin
            if (exp_pop)  void'(fq.pop_front());
            if (exp_push) fq.push_back({m_reqpc + 32'd4, imem_rdata});
            if (m_out && imem_rvalid) begin m_out = 1'b0; m_drop = 1'b0; end
            if (exp_issue) begin
                m_out   = 1'b1;
                m_reqpc = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end
    endfunction

    // ---------------- cycle helpers (no checking) ----------------
    task automatic mem_tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pend) begin
            mem_wait--;
            if (mem_wait == 0) begin
                imem_rvalid = 1'b1;
                mem_pend    = 1'b0;
            end
        end
    endtask

    task automatic begin_cycle();
        mem_tick();
        #1;
        model_expect();
    endtask

    task automatic end_cycle();
        if (imem_req === 1'b1) begin
            mem_pend = 1'b1;
            mem_wait = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            req_count++;
        end
        @(posedge Clk);
        model_update();
        @(negedge Clk);
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        StallD      = 1'b0;
        PCSrcD      = 1'b0;
        PCBranchD   = 32'h0;
        imem_rvalid = 1'b0;
        mem_pend    = 1'b0;
        mem_rand    = 1'b0;
        repeat (2) @(negedge Clk);
        model_reset();
        req_count = 0;
        reset     = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            mem_tick();
            #1;
            checks++;
            if (dut_out !== {1'b0, RESET_PC, 1'b0, 64'h0}) begin
                errors++;
                $display("FAIL reset_state c%0d: got %h exp %h", i, dut_out, {1'b0, RESET_PC, 1'b0, 64'h0});
            end
            @(posedge Clk);
            @(negedge Clk);
        end
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        apply_reset();
        mem_lat = 1;
        for (int k = 0; k < 16; k++) begin
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL stream_model c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_addr c%0d: got req=%b addr=%h exp req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
            end
            if (k >= 2) begin
                checks++;
                if (ValidD !== 1'b1 || PCPlus4D !== 32'(4 * (k - 1))) begin
                    errors++;
                    $display("FAIL stream_head c%0d: got valid=%b pc4=%h exp valid=1 pc4=%h", k, ValidD, PCPlus4D, 32'(4 * (k - 1)));
                end
            end
            end_cycle();
        end
    endtask

    task automatic test_stall_fill();
        logic [31:0] exp_pc4;
        apply_reset();
        mem_lat = 1;
        StallD  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL stall_model c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            end_cycle();
        end
        checks++;
        if (req_count !== DEPTH) begin
            errors++;
            $display("FAIL stall_req_count: got %0d exp %0d", req_count, DEPTH);
        end
        StallD  = 1'b0;
        exp_pc4 = 32'd4;
        for (int k = 0; k < 20; k++) begin
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL drain_model c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            if (exp_pop) begin
                checks++;
                if (PCPlus4D !== exp_pc4) begin
                    errors++;
                    $display("FAIL drain_order c%0d: got pc4=%h exp %h", k, PCPlus4D, exp_pc4);
                end
                exp_pc4 = exp_pc4 + 32'd4;
            end
            end_cycle();
        end
    endtask

    task automatic test_latency3();
        int valid_cycles;
        apply_reset();
        mem_lat      = 3;
        valid_cycles = 0;
        for (int k = 0; k < 24; k++) begin
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL lat3_model c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            if (ValidD === 1'b1) valid_cycles++;
            end_cycle();
        end
        checks++;
        if (req_count !== 8 || valid_cycles !== 7) begin
            errors++;
            $display("FAIL lat3_rate: got reqs=%0d valid=%0d exp reqs=8 valid=7", req_count, valid_cycles);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] first_addr, first_pc4;
        bit          got_addr, got_pc4;
        apply_reset();
        mem_lat  = 3;
        got_addr = 1'b0;
        got_pc4  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            PCSrcD    = (k == 1);
            PCBranchD = 32'h40;
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL redir_wait_model c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            if (k == 2) begin
                checks++;
                if (ValidD !== 1'b0 || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_wait_flush: got valid=%b req=%b exp 0 0", ValidD, imem_req);
                end
            end
            if (k >= 2 && imem_req === 1'b1 && !got_addr) begin got_addr = 1'b1; first_addr = imem_addr; end
            if (k >= 2 && ValidD === 1'b1 && !got_pc4) begin got_pc4 = 1'b1; first_pc4 = PCPlus4D; end
            end_cycle();
        end
        PCSrcD = 1'b0;
        checks++;
        if (!got_addr || first_addr !== 32'h40 || !got_pc4 || first_pc4 !== 32'h44) begin
            errors++;
            $display("FAIL redir_wait_target: got addr=%h(%b) pc4=%h(%b) exp addr=00000040 pc4=00000044",
                     first_addr, got_addr, first_pc4, got_pc4);
        end
    endtask

    task automatic test_redirect_rvalid();
        apply_reset();
        mem_lat = 1;
        for (int k = 0; k < 8; k++) begin
            PCSrcD    = (k == 1);
            PCBranchD = 32'h43;
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL redir_rv_model c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            if (k == 2) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h40 || ValidD !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_rv_next: got req=%b addr=%h valid=%b exp 1 00000040 0", imem_req, imem_addr, ValidD);
                end
            end
            end_cycle();
        end
        PCSrcD = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit          found;
        bit          got_addr;
        logic [31:0] first_addr;
        apply_reset();
        mem_lat = 3;
        StallD  = 1'b1;
        found   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_out && !m_drop && fq.size() == DEPTH - 1) begin found = 1'b1; break; end
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL rmid_fill c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            end_cycle();
        end
        checks++;
        if (!found || ValidD !== 1'b1) begin
            errors++;
            $display("FAIL rmid_setup: got found=%b valid=%b exp 1 1", found, ValidD);
        end
        mem_tick();
        reset = 1'b1;
        #1;
        checks++;
        if (dut_out !== {1'b0, RESET_PC, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL rmid_async: got %h exp %h", dut_out, {1'b0, RESET_PC, 1'b0, 64'h0});
        end
        @(posedge Clk);
        @(negedge Clk);
        for (int k = 0; k < 4 && mem_pend && mem_wait > 1; k++) begin
            mem_tick();
            @(posedge Clk);
            @(negedge Clk);
        end
        model_reset();
        reset    = 1'b0;
        StallD   = 1'b0;
        got_addr = 1'b0;
        for (int k = 0; k < 12; k++) begin
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL rmid_restart c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            if (imem_req === 1'b1 && !got_addr) begin got_addr = 1'b1; first_addr = imem_addr; end
            end_cycle();
        end
        checks++;
        if (!got_addr || first_addr !== RESET_PC) begin
            errors++;
            $display("FAIL rmid_first_addr: got %h(%b) exp %h", first_addr, got_addr, RESET_PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] first_pc4;
        bit          got_pc4;
        apply_reset();
        mem_lat = 1;
        got_pc4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            PCSrcD    = (k == 0);
            PCBranchD = 32'hFFFF_FFFE;
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL wrap_model c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            if (k == 2) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                    errors++;
                    $display("FAIL wrap_addr: got req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
                end
            end
            if (ValidD === 1'b1 && !got_pc4) begin got_pc4 = 1'b1; first_pc4 = PCPlus4D; end
            end_cycle();
        end
        PCSrcD = 1'b0;
        checks++;
        if (!got_pc4 || first_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4: got %h(%b) exp 00000000", first_pc4, got_pc4);
        end
    endtask

    task automatic test_random();
        apply_reset();
        mem_rand = 1'b1;
        for (int k = 0; k < 500; k++) begin
            StallD    = ($urandom_range(0, 9) < 3);
            PCSrcD    = ($urandom_range(0, 19) == 0);
            PCBranchD = $urandom;
            begin_cycle();
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL random_model c%0d: got %h exp %h", k, dut_out, exp_out);
            end
            end_cycle();
        end
        StallD   = 1'b0;
        PCSrcD   = 1'b0;
        mem_rand = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        StallD      = 1'b0;
        PCSrcD      = 1'b0;
        PCBranchD   = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_pend    = 1'b0;
        mem_rand    = 1'b0;
        mem_lat     = 1;
        req_count   = 0;
        model_reset();
        @(negedge Clk);
        test_reset();
        test_stream();
        test_stall_fill();
        test_latency3();
        test_redirect_wait();
        test_redirect_rvalid();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
